// File: rtl/seq_detect_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_param_if
//  Description : Bundle of control, data and status signals between a serial
//                stream source and the parametrised pattern detector.
//  Revision    : 1.0  initial release
// ============================================================================
interface seq_detect_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             en;
    logic             data;
    logic             overlap;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             cnt_clr;
    logic             match;
    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] pat;
    logic [CNT_W-1:0] match_cnt;

    // Stream source / controller side
    modport master (
        output en, data, overlap, pat_load, pat_in, cnt_clr,
        input  match, hist, pat, match_cnt
    );

    // Detector side
    modport slave (
        input  en, data, overlap, pat_load, pat_in, cnt_clr,
        output match, hist, pat, match_cnt
    );
endinterface
`default_nettype wire

// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_param
//  Description : Parametrised serial bit-pattern detector with runtime pattern
//                reload, overlapping / non-overlapping modes, fill guard and a
//                saturating match counter. Registered (Moore) match output.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_detect_param #(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter int             CNT_W   = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    seq_detect_param_if.slave  bus
);
    // Fill counter must hold 0..PAT_W inclusive
    localparam int               FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] C_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  C_CMAX = {CNT_W{1'b1}};

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [PAT_W-1:0]  pat_q,  pat_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              match_q, match_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;

    logic [PAT_W-1:0]  h_next;
    logic [FILL_W-1:0] f_next;
    logic              hit;

    // Candidate history/fill after consuming the current bit, and the hit test
    always_comb begin
        h_next = {hist_q[PAT_W-2:0], bus.data};
        f_next = (fill_q == C_FULL) ? C_FULL : fill_q + 1'b1;
        hit    = bus.en && !bus.pat_load && (f_next == C_FULL) && (h_next == pat_q);
    end

    // Next-state selection: pattern load beats sampling; counter clear beats a hit
    always_comb begin
        hist_d  = hist_q;
        pat_d   = pat_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        cnt_d   = cnt_q;

        if (bus.pat_load) begin
            pat_d  = bus.pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.en) begin
            match_d = hit;
            if (hit && !bus.overlap) begin
                // Non-overlapping: the next match needs PAT_W fresh bits
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = h_next;
                fill_d = f_next;
            end
        end

        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != C_CMAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q  <= '0;
            pat_q   <= PATTERN;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.match     = match_q;
    assign bus.hist      = hist_q;
    assign bus.pat       = pat_q;
    assign bus.match_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detect_param
//  Description : Self-checking bench for seq_detect_param. Directed scenarios
//                followed by a random stream, compared every cycle against a
//                bit-queue reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_detect_param;
    localparam int             PAT_W   = 4;
    localparam logic [PAT_W-1:0] PATTERN = 4'b1101;
    localparam int             CNT_W   = 2;
    localparam int             CMAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq_detect_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    seq_detect_param #(.PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: the bits sampled since the last clear, oldest first
    bit               m_bits[$];
    logic [PAT_W-1:0] m_pat;
    logic             m_match;
    int               m_cnt;
    int               errors = 0;
    int               checks = 0;
    int               n_hi;

    function automatic logic [PAT_W-1:0] packed_bits();
        logic [PAT_W-1:0] v = '0;
        foreach (m_bits[i]) v = {v[PAT_W-2:0], m_bits[i]};
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance model, compare all outputs after the edge
    task automatic step(input bit e = 1'b0, input bit d = 1'b0, input bit ov = 1'b1,
                        input bit pl = 1'b0, input logic [PAT_W-1:0] pi = '0,
                        input bit cc = 1'b0, input bit r = 1'b0);
        bit hit;
        rst          = r;
        bus.en       = e;
        bus.data     = d;
        bus.overlap  = ov;
        bus.pat_load = pl;
        bus.pat_in   = pi;
        bus.cnt_clr  = cc;
        @(posedge clk);
        hit = 1'b0;
        if (r) begin
            m_bits.delete();
            m_pat   = PATTERN;
            m_match = 1'b0;
            m_cnt   = 0;
        end else begin
            if (pl) begin
                m_pat = pi;
                m_bits.delete();
            end else if (e) begin
                m_bits.push_back(d);
                if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
                hit = (m_bits.size() == PAT_W) && (packed_bits() == m_pat);
                if (hit && !ov) m_bits.delete();
            end
            m_match = hit;
            if (cc)                     m_cnt = 0;
            else if (hit && m_cnt < CMAX) m_cnt = m_cnt + 1;
        end
        #1;
        chk("match",     32'(bus.match),     32'(m_match));
        chk("hist",      32'(bus.hist),      32'(packed_bits()));
        chk("pat",       32'(bus.pat),       32'(m_pat));
        chk("match_cnt", 32'(bus.match_cnt), 32'(m_cnt));
        if (bus.match === 1'b1) n_hi++;
    endtask

    task automatic feed(input logic [PAT_W-1:0] v, input bit ov = 1'b1);
        for (int i = PAT_W - 1; i >= 0; i--) step(.e(1'b1), .d(v[i]), .ov(ov));
    endtask

    initial begin
        bus.en = 0; bus.data = 0; bus.overlap = 1; bus.pat_load = 0;
        bus.pat_in = '0; bus.cnt_clr = 0;
        m_pat = PATTERN; m_match = 0; m_cnt = 0; n_hi = 0;

        // Reset state
        step(.r(1'b1));
        chk("rst_pat",  32'(bus.pat), 32'(4'b1101));
        chk("rst_hist", 32'(bus.hist), 32'h0);

        // Default pattern 1101
        feed(4'b1101);
        chk("dflt_match", 32'(bus.match), 32'h1);
        chk("dflt_cnt",   32'(bus.match_cnt), 32'h1);
        chk("dflt_hist",  32'(bus.hist), 32'(4'b1101));
        step();
        chk("dflt_pulse", 32'(bus.match), 32'h0);

        // Fill guard with all-zero pattern
        step(.r(1'b1));
        step(.pl(1'b1), .pi(4'b0000));
        for (int i = 0; i < 3; i++) begin
            step(.e(1'b1), .d(1'b0));
            chk("guard_nomatch", 32'(bus.match), 32'h0);
        end
        step(.e(1'b1), .d(1'b0));
        chk("guard_match", 32'(bus.match), 32'h1);

        // 1111 overlapping: four consecutive matches, counter saturates at 3
        step(.r(1'b1));
        step(.pl(1'b1), .pi(4'b1111));
        n_hi = 0;
        for (int i = 0; i < 7; i++) step(.e(1'b1), .d(1'b1), .ov(1'b1));
        chk("ovl_hits", 32'(n_hi), 32'd4);
        chk("ovl_cnt",  32'(bus.match_cnt), 32'd3);

        // 1111 non-overlapping: single match
        step(.r(1'b1));
        step(.pl(1'b1), .pi(4'b1111));
        n_hi = 0;
        for (int i = 0; i < 7; i++) step(.e(1'b1), .d(1'b1), .ov(1'b0));
        chk("novl_hits", 32'(n_hi), 32'd1);
        chk("novl_cnt",  32'(bus.match_cnt), 32'd1);

        // Enable gap holds history
        step(.r(1'b1));
        step(.e(1'b1), .d(1'b1)); step(.e(1'b1), .d(1'b1)); step(.e(1'b1), .d(1'b0));
        for (int i = 0; i < 3; i++) begin
            step(.e(1'b0), .d(1'b1));
            chk("gap_hold", 32'(bus.hist[2:0]), 32'(3'b110));
        end
        step(.e(1'b1), .d(1'b1));
        chk("gap_match", 32'(bus.match), 32'h1);

        // Pattern reload mid-stream
        step(.r(1'b1));
        step(.e(1'b1), .d(1'b1)); step(.e(1'b1), .d(1'b1)); step(.e(1'b1), .d(1'b0));
        step(.e(1'b1), .d(1'b1), .pl(1'b1), .pi(4'b1010));
        chk("load_hist", 32'(bus.hist), 32'h0);
        n_hi = 0;
        feed(4'b1101);
        chk("load_old_nomatch", 32'(n_hi), 32'd0);
        feed(4'b1010);
        chk("load_new_match", 32'(bus.match), 32'h1);
        chk("load_pat", 32'(bus.pat), 32'(4'b1010));

        // Saturation with nine separate occurrences
        step(.r(1'b1));
        for (int i = 0; i < 9; i++) feed(4'b1101, 1'b0);
        chk("sat_cnt", 32'(bus.match_cnt), 32'd3);

        // Clear coinciding with a hit
        step(.e(1'b1), .d(1'b1)); step(.e(1'b1), .d(1'b1)); step(.e(1'b1), .d(1'b0));
        step(.e(1'b1), .d(1'b1), .cc(1'b1));
        chk("clr_hit_match", 32'(bus.match), 32'h1);
        chk("clr_hit_cnt",   32'(bus.match_cnt), 32'd0);

        // Reset mid-pattern discards partial history
        step(.e(1'b1), .d(1'b1)); step(.e(1'b1), .d(1'b1)); step(.e(1'b1), .d(1'b0));
        step(.r(1'b1));
        step(.e(1'b1), .d(1'b1));
        chk("rst_mid_nomatch", 32'(bus.match), 32'h0);
        step(.e(1'b1), .d(1'b1)); step(.e(1'b1), .d(1'b0)); step(.e(1'b1), .d(1'b1));
        chk("rst_mid_match", 32'(bus.match), 32'h1);

        // Random stream against the model
        for (int i = 0; i < 600; i++) begin
            step(.e($urandom_range(0, 9) != 0),
                 .d($urandom_range(0, 1) != 0),
                 .ov($urandom_range(0, 3) != 0),
                 .pl($urandom_range(0, 39) == 0),
                 .pi(PAT_W'($urandom_range(0, 15))),
                 .cc($urandom_range(0, 29) == 0),
                 .r($urandom_range(0, 79) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial bit-pattern detector for single-bit input streams. Successor to the fixed 4-bit "1101" Moore detector. Adds:
- configurable pattern length and value, with a runtime pattern reload
- overlapping and non-overlapping match modes
- a sample enable
- a fill guard, so that post-reset zeros never produce a false match
- a saturating match counter

Sits between a serial input synchroniser and status/interrupt logic.

Parameters:
PAT_W, 4, pattern length in bits (2..16).
PATTERN, 4'b1101, reset-time pattern; MSB is the oldest bit, LSB is the newest.
CNT_W, 8, match counter width (1..32).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  sample enable; data is consumed only when en=1.
data  input  1  serial input bit.
overlap  input  1  1 = overlapping matches allowed; 0 = history cleared after each match.
pat_load  input  1  loads pat_in as the new pattern and clears history.
pat_in  input  PAT_W  new pattern value.
cnt_clr  input  1  clears match_cnt.
match  output  1  registered Moore output; one-cycle pulse per detected match.
hist  output  PAT_W  current shift history, newest bit at LSB.
pat  output  PAT_W  active pattern.
match_cnt  output  CNT_W  saturating count of matches.

Behaviour:
- Reset (rst=1 at an edge), which overrides all other inputs:
  - hist=0, fill=0, pat=PATTERN, match=0, match_cnt=0.
- Internal fill counter, 0..PAT_W. A match requires fill==PAT_W, i.e. PAT_W valid bits sampled since the last reset, load or clear.
- Priority per edge: rst > pat_load > en sampling.
- pat_load=1 (no rst):
  - pat<=pat_in, hist<=0, fill<=0, match<=0.
  - data is ignored that cycle.
  - The new pattern applies to bits sampled from the next edge onward.
- en=0 (no rst/pat_load): hist and fill hold; match<=0.
- en=1:
  - h_next={hist[PAT_W-2:0],data}.
  - f_next=min(fill+1,PAT_W).
  - hit=(f_next==PAT_W)&&(h_next==pat).
  - match<=hit.
- Latency: match goes high the cycle after the edge that sampled the completing bit. It is high for exactly one cycle per hit, unless hits occur back-to-back.
- On hit with overlap=1: hist<=h_next, fill<=PAT_W, so a further match is possible on the very next bit (e.g. pattern 1111).
- On hit with overlap=0: hist<=0, fill<=0. The next match needs PAT_W fresh bits.
- On no hit: hist<=h_next, fill<=f_next.
- overlap is sampled on the hit edge only. Changing it mid-stream has no other effect.
- match_cnt:
  - increments by 1 on every edge where hit=1.
  - saturates at 2^CNT_W-1 with no wrap.
- cnt_clr: match_cnt<=0. If a hit occurs on the same edge, the clear wins and the count is 0.
- Outputs hist and pat are direct register values. There are no combinational paths from inputs to outputs.
- Reset asserted mid-pattern discards partial history. No match can occur until PAT_W new bits are sampled.

Test Plan:
- Reset then en=1, data stream 1,1,0,1 (defaults) -> match=1 exactly one cycle after the 4th bit's edge; match_cnt=1; hist=4'b1101.
- Reset then en=1, data all 0 with pat loaded to 4'b0000 -> no match on bits 1-3; first match only after the 4th bit (fill guard).
- Pattern 4'b1111, stream of seven 1s:
  - overlap=1 -> matches after bits 4,5,6,7; match high 4 consecutive cycles; match_cnt=4.
  - overlap=0 -> matches after bits 4 only (bit 8 would be next); match_cnt=1.
- Stream 1,1,0 then en=0 for 3 cycles, then en=1 with data 1 -> match after the resumed bit. match=0 throughout the en=0 cycles; hist holds 3'b110 in its low bits.
- pat_load with pat_in=4'b1010 after bits 1,1,0 -> history cleared. Stream 1,1,0,1 gives no match; a subsequent 1,0,1,0 gives a match; pat=4'b1010.
- CNT_W=2, nine separate 1101 occurrences -> match_cnt stops at 3.
  - cnt_clr coinciding with a hit -> match_cnt=0.
  - rst asserted after bits 1,1,0 -> no match until 4 new bits are sampled.
